// File: rtl/miner_work_scheduler.sv
// Work-unit sequencer for the double-SHA256 hasher pair with golden-nonce FIFO.
// Optional macro NONCE_LIMIT_EN adds work_nonce_end to bound the nonce range.
module miner_work_scheduler #(
  parameter int LOOP_LOG2     = 0,
  parameter int FLUSH_CYCLES  = 140,
  parameter int GN_FIFO_DEPTH = 4
) (
  input  logic         hash_clk,
  input  logic         reset,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_midstate,
  input  logic [95:0]  work_data,
  input  logic [31:0]  work_nonce_start,
`ifdef NONCE_LIMIT_EN
  input  logic [31:0]  work_nonce_end,
`endif
  output logic [5:0]   hs_cnt,
  output logic         hs_feedback,
  output logic [255:0] hs_state,
  output logic [511:0] hs_data,
  output logic [31:0]  hs_nonce,
  input  logic [31:0]  hash2_top,
  output logic         gn_valid,
  input  logic         gn_ready,
  output logic [31:0]  gn_nonce,
  output logic [7:0]   gn_drop_cnt,
  output logic         busy,
  output logic         done
);

  localparam logic [5:0] LOOP_MASK = 6'((1 << LOOP_LOG2) - 1);
  localparam int GN_OFFSET = (LOOP_LOG2 == 0) ? 131 :
                             (LOOP_LOG2 == 1) ? 66  : ((1 << (7 - LOOP_LOG2)) + 1);
  localparam int FLUSH_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_CYCLES);
  localparam int AW = $clog2(GN_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [383:0] SHA_PAD = {32'h0000_0280, 320'h0, 32'h8000_0000};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [5:0]           hs_cnt_q, hs_cnt_d;
  logic                 hs_fb_q, hs_fb_d;
  logic [255:0]         hs_state_q, hs_state_d;
  logic [511:0]         hs_data_q, hs_data_d;
  logic [31:0]          hs_nonce_q, hs_nonce_d;
  logic [FLUSH_W-1:0]   flush_q, flush_d;
  logic                 done_q, done_d;
  logic                 fb_d1_q;
  logic                 golden_q, golden_d;
  logic [31:0]          last_nonce_s;

  logic [31:0]          mem_q [GN_FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic [7:0]           drop_q;

  logic                 take_s, wrap_s, last_issue_s, flush_zero_s;
  logic [5:0]           cnt_next_s;
  logic                 push_s, pop_s, full_s, wr_en_s, drop_s;
  logic [31:0]          gn_nonce_in_s;

`ifdef NONCE_LIMIT_EN
  logic [31:0] last_q, last_d;
  assign last_nonce_s = last_q;
`else
  assign last_nonce_s = 32'hFFFF_FFFF;
`endif

  assign work_ready   = 1'b1;
  assign take_s       = work_valid && work_ready;
  assign cnt_next_s   = (hs_cnt_q + 6'd1) & LOOP_MASK;
  assign wrap_s       = (cnt_next_s == 6'd0);
  assign flush_zero_s = (flush_q == '0);
  assign last_issue_s = (state_q == RUN) && wrap_s && (hs_nonce_q == last_nonce_s);

  // FSM state register
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a handshake preempts whatever is in flight
  always_comb begin
    state_d = state_q;
    if (take_s) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     state_d = last_issue_s ? DRAIN : RUN;
        DRAIN:   state_d = flush_zero_s ? IDLE : DRAIN;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
  end

  // Hasher-facing datapath next values
  always_comb begin
    hs_cnt_d   = hs_cnt_q;
    hs_fb_d    = hs_fb_q;
    hs_state_d = hs_state_q;
    hs_nonce_d = hs_nonce_q;
    hs_data_d  = hs_data_q;
    flush_d    = flush_q;
`ifdef NONCE_LIMIT_EN
    last_d     = last_q;
`endif
    if (take_s) begin
      hs_cnt_d   = 6'd0;
      hs_fb_d    = 1'b0;
      hs_state_d = work_midstate;
      hs_nonce_d = work_nonce_start;
      hs_data_d  = {SHA_PAD, work_nonce_start, work_data};
      flush_d    = FLUSH_INIT;
`ifdef NONCE_LIMIT_EN
      last_d     = (work_nonce_end < work_nonce_start) ? 32'hFFFF_FFFF : work_nonce_end;
`endif
    end else begin
      case (state_q)
        RUN: begin
          hs_cnt_d = cnt_next_s;
          hs_fb_d  = (LOOP_LOG2 != 0) && !wrap_s;
          if (last_issue_s) begin
            // Reload so DRAIN waits out the hasher pipeline for the final nonce
            flush_d = FLUSH_INIT;
          end else begin
            if (!flush_zero_s) flush_d = flush_q - FLUSH_W'(1);
            if (wrap_s)        hs_nonce_d = hs_nonce_q + 32'd1;
          end
          hs_data_d = {SHA_PAD, hs_nonce_d, hs_data_q[95:0]};
        end
        DRAIN: begin
          if (!flush_zero_s) flush_d = flush_q - FLUSH_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Golden detection and done pulse next values
  always_comb begin
    golden_d = (hash2_top == 32'd0) && !fb_d1_q && !take_s &&
               (((state_q == RUN) && flush_zero_s) || (state_q == DRAIN));
    done_d   = (state_q == DRAIN) && flush_zero_s && !take_s;
  end

  // Hasher-facing registers
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      hs_cnt_q   <= 6'd0;
      hs_fb_q    <= 1'b0;
      hs_state_q <= 256'd0;
      hs_data_q  <= 512'd0;
      hs_nonce_q <= 32'd0;
      flush_q    <= FLUSH_INIT;
      done_q     <= 1'b0;
      fb_d1_q    <= 1'b0;
      golden_q   <= 1'b0;
`ifdef NONCE_LIMIT_EN
      last_q     <= 32'hFFFF_FFFF;
`endif
    end else begin
      hs_cnt_q   <= hs_cnt_d;
      hs_fb_q    <= hs_fb_d;
      hs_state_q <= hs_state_d;
      hs_data_q  <= hs_data_d;
      hs_nonce_q <= hs_nonce_d;
      flush_q    <= flush_d;
      done_q     <= done_d;
      fb_d1_q    <= hs_fb_q;
      golden_q   <= golden_d;
`ifdef NONCE_LIMIT_EN
      last_q     <= last_d;
`endif
    end
  end

  assign hs_cnt      = hs_cnt_q;
  assign hs_feedback = hs_fb_q;
  assign hs_state    = hs_state_q;
  assign hs_data     = hs_data_q;
  assign hs_nonce    = hs_nonce_q;

  // The hasher pipeline lags issue, so the winning nonce is behind the current one
  assign gn_nonce_in_s = hs_nonce_q - 32'(GN_OFFSET);
  assign push_s  = golden_q;
  assign pop_s   = (count_q != '0) && gn_ready;
  assign full_s  = (count_q == CW'(GN_FIFO_DEPTH));
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  // FIFO occupancy next value
  always_comb begin
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Golden-nonce FIFO storage, pointers and drop counter
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < GN_FIFO_DEPTH; i++) mem_q[i] <= 32'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 8'd0;
    end else begin
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= gn_nonce_in_s;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (drop_s && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  assign gn_valid    = (count_q != '0);
  assign gn_nonce    = mem_q[rd_ptr_q];
  assign gn_drop_cnt = drop_q;

endmodule

// File: tb/tb_miner_work_scheduler.sv
// Scoreboard bench for miner_work_scheduler with a stubbed hash2_top (LOOP=4, flush=8, 4-deep FIFO).
module tb_miner_work_scheduler;
  localparam int FLUSH = 8;

  logic         hash_clk = 1'b0;
  logic         reset = 1'b1;
  logic         work_valid = 1'b0;
  logic         work_ready;
  logic [255:0] work_midstate = 256'd0;
  logic [95:0]  work_data = 96'd0;
  logic [31:0]  work_nonce_start = 32'd0;
  logic [31:0]  work_nonce_end = 32'd0;
  logic [5:0]   hs_cnt;
  logic         hs_feedback;
  logic [255:0] hs_state;
  logic [511:0] hs_data;
  logic [31:0]  hs_nonce;
  logic [31:0]  hash2_top = 32'd1;
  logic         gn_valid;
  logic         gn_ready = 1'b0;
  logic [31:0]  gn_nonce;
  logic [7:0]   gn_drop_cnt;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_n;

  miner_work_scheduler #(.LOOP_LOG2(2), .FLUSH_CYCLES(FLUSH), .GN_FIFO_DEPTH(4)) dut (
    .hash_clk(hash_clk), .reset(reset), .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_data(work_data), .work_nonce_start(work_nonce_start),
`ifdef NONCE_LIMIT_EN
    .work_nonce_end(work_nonce_end),
`endif
    .hs_cnt(hs_cnt), .hs_feedback(hs_feedback), .hs_state(hs_state), .hs_data(hs_data),
    .hs_nonce(hs_nonce), .hash2_top(hash2_top), .gn_valid(gn_valid), .gn_ready(gn_ready),
    .gn_nonce(gn_nonce), .gn_drop_cnt(gn_drop_cnt), .busy(busy), .done(done)
  );

  always #5 hash_clk = ~hash_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; work_valid = 1'b0; hash2_top = 32'd1; gn_ready = 1'b0;
    exp_q.delete();
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic handshake(input logic [31:0] start);
    work_valid       = 1'b1;
    work_nonce_start = start;
    work_midstate    = {8{start ^ 32'h2b3f_8126}};
    work_data        = 96'h39f3001b_6b7b8d4d_c14bfc31;
    step();
    work_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (work_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready got %b want 1", work_ready); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (hs_cnt !== 6'd0)       begin errors++; $display("FAIL reset_cnt got %0d want 0", hs_cnt); end
    checks++; if (hs_feedback !== 1'b0)  begin errors++; $display("FAIL reset_fb got %b want 0", hs_feedback); end
    checks++; if (hs_state !== 256'd0)   begin errors++; $display("FAIL reset_state got %h want 0", hs_state); end
    checks++; if (hs_data !== 512'd0)    begin errors++; $display("FAIL reset_data got %h want 0", hs_data); end
    checks++; if (hs_nonce !== 32'd0)    begin errors++; $display("FAIL reset_nonce got %h want 0", hs_nonce); end
    checks++; if (gn_valid !== 1'b0)     begin errors++; $display("FAIL reset_gn_valid got %b want 0", gn_valid); end
    checks++; if (gn_nonce !== 32'd0)    begin errors++; $display("FAIL reset_gn_nonce got %h want 0", gn_nonce); end
    checks++; if (gn_drop_cnt !== 8'd0)  begin errors++; $display("FAIL reset_drop got %0d want 0", gn_drop_cnt); end
    checks++; if (done !== 1'b0)         begin errors++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  // Goldens land every 4 cycles once flush expires; only 4 fit, the rest are counted as drops
  task automatic test_fifo_overflow();
    logic [31:0] s;
    do_reset();
    s = 32'h0000_1000;
    hash2_top = 32'd0;
    handshake(s);
    for (int j = 0; j < 4; j++) exp_q.push_back(s - 32'd31 + 32'(j));
    repeat (31) step();
    hash2_top = 32'd1;
    repeat (2) step();
    checks++; if (gn_drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop got %0d want 2", gn_drop_cnt); end
    checks++; if (gn_valid !== 1'b1)    begin errors++; $display("FAIL ovf_valid got %b want 1", gn_valid); end
    gn_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_n = exp_q.pop_front();
      checks++; if (gn_valid !== 1'b1) begin errors++; $display("FAIL ovf_pop_valid[%0d] got %b want 1", j, gn_valid); end
      checks++; if (gn_nonce !== exp_n) begin errors++; $display("FAIL ovf_pop_nonce[%0d] got %h want %h", j, gn_nonce, exp_n); end
      step();
    end
    checks++; if (gn_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", gn_valid); end
    gn_ready = 1'b0;
  endtask

  task automatic test_flush_preempt();
    logic [31:0] s2;
    do_reset();
    hash2_top = 32'd0;
    handshake(32'h0000_2000);
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++; if (gn_valid !== 1'b0) begin errors++; $display("FAIL pre_first[%0d] got %b want 0", k, gn_valid); end
    end
    s2 = 32'h0000_5000;
    handshake(s2);
    exp_q.push_back(s2 - 32'd31);
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++; if (gn_valid !== 1'b0) begin errors++; $display("FAIL pre_second[%0d] got %b want 0", k, gn_valid); end
    end
    step();
    exp_n = exp_q.pop_front();
    checks++; if (gn_valid !== 1'b1)  begin errors++; $display("FAIL pre_golden_valid got %b want 1", gn_valid); end
    checks++; if (gn_nonce !== exp_n) begin errors++; $display("FAIL pre_golden_nonce got %h want %h", gn_nonce, exp_n); end
    hash2_top = 32'd1;
  endtask

  task automatic test_last_nonce();
    logic [31:0] en;
    logic [5:0]  ec;
    logic        eb, ed;
    logic [511:0] edata;
    do_reset();
    handshake(32'hFFFF_FFFE);
    checks++; if (hs_state !== {8{32'hFFFF_FFFE ^ 32'h2b3f_8126}}) begin errors++; $display("FAIL last_state got %h", hs_state); end
    for (int k = 1; k <= 18; k++) begin
      step();
      en = (k < 4) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
      ec = (k < 8) ? 6'(k % 4) : 6'd0;
      eb = (k <= 16);
      ed = (k == 17);
      checks++; if (hs_nonce !== en) begin errors++; $display("FAIL last_nonce[%0d] got %h want %h", k, hs_nonce, en); end
      checks++; if (hs_cnt !== ec)   begin errors++; $display("FAIL last_cnt[%0d] got %0d want %0d", k, hs_cnt, ec); end
      checks++; if (busy !== eb)     begin errors++; $display("FAIL last_busy[%0d] got %b want %b", k, busy, eb); end
      checks++; if (done !== ed)     begin errors++; $display("FAIL last_done[%0d] got %b want %b", k, done, ed); end
      if (k == 5) begin
        edata = {32'h0000_0280, 320'h0, 32'h8000_0000, 32'hFFFF_FFFF, 96'h39f3001b_6b7b8d4d_c14bfc31};
        checks++; if (hs_data !== edata) begin errors++; $display("FAIL last_data got %h want %h", hs_data, edata); end
        checks++; if (hs_feedback !== 1'b1) begin errors++; $display("FAIL last_fb got %b want 1", hs_feedback); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    hash2_top = 32'd0;
    handshake(32'h0000_3000);
    repeat (12) step();
    checks++; if (gn_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", gn_valid); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL mid_pre_busy got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    checks++; if (gn_valid !== 1'b0)  begin errors++; $display("FAIL mid_gn_valid got %b want 0", gn_valid); end
    checks++; if (hs_nonce !== 32'd0) begin errors++; $display("FAIL mid_nonce got %h want 0", hs_nonce); end
    step();
    reset = 1'b0;
    hash2_top = 32'd1;
    step();
    checks++; if (work_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", work_ready); end
    checks++; if (hs_cnt !== 6'd0)     begin errors++; $display("FAIL mid_cnt got %0d want 0", hs_cnt); end
  endtask

`ifdef NONCE_LIMIT_EN
  task automatic test_nonce_limit();
    do_reset();
    work_nonce_end = 32'h0000_0010;
    handshake(32'd0);
    for (int k = 1; k <= 77; k++) begin
      step();
      if (k == 67 || k == 68) begin
        checks++; if (hs_nonce !== 32'h10) begin errors++; $display("FAIL lim_nonce[%0d] got %h want 10", k, hs_nonce); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL lim_busy[%0d] got %b want 1", k, busy); end
      end
    end
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL lim_end got busy=%b done=%b want 0/1", busy, done); end
    work_nonce_end = 32'd0;
    handshake(32'd5);
    repeat (100) step();
    checks++; if (hs_nonce !== 32'h1E || busy !== 1'b1) begin errors++; $display("FAIL lim_wrap got %h busy=%b want 1e/1", hs_nonce, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_fifo_overflow();
    test_flush_preempt();
    test_last_nonce();
    test_reset_mid_run();
`ifdef NONCE_LIMIT_EN
    test_nonce_limit();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
